// File: rtl/vram_pkg.sv
// vram_pkg: shared command/state types and default widths for vram_port.
//   VRAM_AW / VRAM_DW : default address / data widths
//   vram_cmd_t        : queued request {we, addr, data}
//   vram_state_t      : sequencer states
package vram_pkg;

    localparam int VRAM_AW = 16;
    localparam int VRAM_DW = 16;

    typedef struct packed {
        logic               we;
        logic [VRAM_AW-1:0] addr;
        logic [VRAM_DW-1:0] data;
    } vram_cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} vram_state_t;

endpackage

// File: rtl/vram_port_sync_fifo.sv
// sync_fifo: in-order FIFO with up to two pushes per cycle and a registered head.
//   clk, reset_n  : clock, asynchronous active-low reset
//   push_a, din_a : first entry written this cycle
//   push_b, din_b : second entry, queued behind din_a when both push
//   pop           : drop the head (ignored when empty)
//   empty, count  : occupancy after the current edge
//   head          : registered copy of the oldest entry, valid when !empty
// The caller guarantees there is room for every push it makes.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_a,
    input  logic [WIDTH-1:0] din_a,
    input  logic             push_b,
    input  logic [WIDTH-1:0] din_b,
    input  logic             pop,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0]    kept;
    logic [WIDTH-1:0] head_n;
    logic             do_pop;

    // The next head comes from storage if older entries survive the pop,
    // otherwise from whichever entry is being pushed first this cycle.
    always_comb begin
        do_pop   = pop && count != '0;
        rd_ptr_n = rd_ptr + PW'(do_pop);
        kept     = count - CW'(do_pop);
        head_n   = kept != '0 ? mem[rd_ptr_n] : push_a ? din_a : push_b ? din_b : head;
    end

    always_ff @(posedge clk) begin
        if (push_a) mem[wr_ptr] <= din_a;
        if (push_b) mem[wr_ptr + PW'(push_a)] <= din_b;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
            rd_ptr <= rd_ptr_n;
            count  <= count + CW'(push_a) + CW'(push_b) - CW'(do_pop);
            head   <= head_n;
        end
    end

    assign empty = count == '0;

endmodule

// File: rtl/vram_port.sv
// vram_port: queues game-side write/read requests and issues them in order to the
// frame-store controller over a req/ack handshake, buffering returned read data.
//   clk, reset_n                   : clock, asynchronous active-low reset
//   write, writeaddr, writedata    : write request (one cycle = one request)
//   read, readaddr                 : read request (one cycle = one request)
//   wr_full                        : command queue has fewer than two free slots
//   rd_empty, readdata, rd_pop     : read-data queue status, head, consume
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ack             : memory transaction handshake
//   mem_rvalid, mem_rdata          : returned read data
//   overflow                       : sticky, a request arrived while wr_full
//   busy                           : sequencer active or commands queued
module vram_port
    import vram_pkg::*;
#(
    parameter int AW        = VRAM_AW,
    parameter int DW        = VRAM_DW,
    parameter int CMD_DEPTH = 4,
    parameter int RD_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          write,
    input  logic [AW-1:0] writeaddr,
    input  logic [DW-1:0] writedata,
    input  logic          read,
    input  logic [AW-1:0] readaddr,
    output logic          wr_full,
    output logic          rd_empty,
    output logic [DW-1:0] readdata,
    input  logic          rd_pop,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          overflow,
    output logic          busy
);

    localparam int CMD_W = 1 + AW + DW;
    localparam int CCW   = $clog2(CMD_DEPTH) + 1;
    localparam int RCW   = $clog2(RD_DEPTH) + 1;

    vram_state_t      state, state_n;
    logic [CMD_W-1:0] cmd_head;
    logic [CCW-1:0]   cmd_count;
    logic [RCW-1:0]   rd_count;
    logic             cmd_empty, cmd_pop, rd_push;
    logic             push_w, push_r, head_we, start;

    // Both requests share one room check; two free slots are always kept,
    // so a same-cycle write+read never splits.
    assign wr_full = cmd_count >= CCW'(CMD_DEPTH - 1);
    assign push_w  = write && !wr_full;
    assign push_r  = read && !wr_full;
    assign head_we = cmd_head[CMD_W-1];

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd (
        .clk     (clk),
        .reset_n (reset_n),
        .push_a  (push_w),
        .din_a   ({1'b1, writeaddr, writedata}),
        .push_b  (push_r),
        .din_b   ({1'b0, readaddr, {DW{1'b0}}}),
        .pop     (cmd_pop),
        .empty   (cmd_empty),
        .count   (cmd_count),
        .head    (cmd_head)
    );

    sync_fifo #(.WIDTH(DW), .DEPTH(RD_DEPTH)) u_rd (
        .clk     (clk),
        .reset_n (reset_n),
        .push_a  (rd_push),
        .din_a   (mem_rdata),
        .push_b  (1'b0),
        .din_b   ({DW{1'b0}}),
        .pop     (rd_pop),
        .empty   (rd_empty),
        .count   (rd_count),
        .head    (readdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // A read only starts when its data is sure to find a slot; no read is
    // outstanding while IDLE, so the buffered count alone decides.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (!cmd_empty && (head_we || rd_count < RCW'(RD_DEPTH))) state_n = ISSUE;
            ISSUE:   if (mem_ack) state_n = mem_we ? IDLE : WAIT_RD;
            WAIT_RD: if (mem_rvalid) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        mem_req = state == ISSUE;
        cmd_pop = state == ISSUE && mem_ack;
        rd_push = state == WAIT_RD && mem_rvalid;
        start   = state == IDLE && state_n == ISSUE;
        busy    = state != IDLE || !cmd_empty;
    end

    // Transaction fields are captured once on entry to ISSUE so they stay
    // stable through the handshake and hold afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (start) begin
            mem_we    <= head_we;
            mem_addr  <= cmd_head[DW +: AW];
            mem_wdata <= cmd_head[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           overflow <= 1'b0;
        else if ((write || read) && wr_full)    overflow <= 1'b1;
    end

endmodule

// File: tb/tb_vram_port.sv
// tb_vram_port: directed and randomized checks of vram_port against an in-order
// request/memory model and a behavioural memory controller.
module tb_vram_port;
    import vram_pkg::*;

    localparam int AW = 16, DW = 16, CMD_DEPTH = 4, RD_DEPTH = 4;

    logic          clk = 0, reset_n = 1;
    logic          write = 0, read = 0, rd_pop = 0, mem_ack = 0, mem_rvalid = 0;
    logic [AW-1:0] writeaddr = 0, readaddr = 0;
    logic [DW-1:0] writedata = 0, mem_rdata = 0;
    logic          wr_full, rd_empty, mem_req, mem_we, overflow, busy;
    logic [DW-1:0] readdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int checks = 0, errors = 0;

    vram_cmd_t     exp_cmd[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] resp_mem[logic [AW-1:0]];
    logic [DW-1:0] shadow[logic [AW-1:0]];
    int            cnt_m = 0, rd_m = 0;
    bit            ov_m = 0, outstanding = 0, hold = 0;
    vram_cmd_t     held;
    int            ack_cnt = 0, ack_dly = 0, lat = 1, rv_cnt = 0;
    bit            ack_hold = 0, rand_mode = 0;
    logic [DW-1:0] rv_data;
    int            n_wr = 0, n_rd = 0, n_req = 0;

    always #5 clk = ~clk;

    vram_port #(.AW(AW), .DW(DW), .CMD_DEPTH(CMD_DEPTH), .RD_DEPTH(RD_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .write(write), .writeaddr(writeaddr), .writedata(writedata),
        .read(read), .readaddr(readaddr),
        .wr_full(wr_full), .rd_empty(rd_empty), .readdata(readdata), .rd_pop(rd_pop),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .overflow(overflow), .busy(busy)
    );

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return a ^ 16'hC35A;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // One clock: account for what the coming edge does, then at the next
    // falling edge act as memory controller and compare outputs to the model.
    task automatic tick();
        vram_cmd_t     c;
        logic [DW-1:0] d;
        bit            full_m;
        full_m = cnt_m >= CMD_DEPTH - 1;
        if (write) begin
            if (!full_m) begin
                exp_cmd.push_back('{1'b1, writeaddr, writedata});
                shadow[writeaddr] = writedata;
                cnt_m++;
            end else ov_m = 1;
        end
        if (read) begin
            if (!full_m) begin
                exp_cmd.push_back('{1'b0, readaddr, 16'h0000});
                exp_rd.push_back(shadow.exists(readaddr) ? shadow[readaddr] : dflt(readaddr));
                cnt_m++;
            end else ov_m = 1;
        end
        if (mem_req && mem_ack) begin
            check("txn_avail", exp_cmd.size() > 0, 1);
            if (exp_cmd.size() > 0) begin
                c = exp_cmd.pop_front();
                check("txn", {mem_we, mem_addr, mem_wdata}, c);
                cnt_m--;
            end
            if (mem_we) begin
                resp_mem[mem_addr] = mem_wdata;
                n_wr++;
            end else begin
                rv_data = resp_mem.exists(mem_addr) ? resp_mem[mem_addr] : dflt(mem_addr);
                rv_cnt = lat;
                outstanding = 1;
                n_rd++;
            end
            ack_cnt = 0;
            if (rand_mode) begin
                ack_dly = $urandom_range(0, 3);
                lat = $urandom_range(1, 4);
            end
        end
        hold = mem_req && !mem_ack;
        held = '{mem_we, mem_addr, mem_wdata};
        if (rd_pop && rd_m > 0) begin
            rd_m--;
            d = exp_rd.pop_front();
        end
        if (mem_rvalid) begin
            rd_m++;
            outstanding = 0;
        end
        @(posedge clk);
        @(negedge clk);
        mem_rvalid = 0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                mem_rvalid = 1;
                mem_rdata = rv_data;
            end
        end
        mem_ack = mem_req && !ack_hold && ack_cnt >= ack_dly;
        if (mem_req) begin
            ack_cnt++;
            n_req++;
        end
        if (hold) begin
            check("hold_req", mem_req, 1);
            check("hold_fields", {mem_we, mem_addr, mem_wdata}, held);
        end
        check("wr_full", wr_full, cnt_m >= CMD_DEPTH - 1);
        check("rd_empty", rd_empty, rd_m == 0);
        check("overflow", overflow, ov_m);
        check("busy", busy, cnt_m != 0 || outstanding);
        if (rd_m > 0) check("readdata", readdata, exp_rd[0]);
    endtask

    task automatic do_reset();
        reset_n = 0;
        write = 0; read = 0; rd_pop = 0; mem_ack = 0; mem_rvalid = 0;
        exp_cmd.delete(); exp_rd.delete();
        shadow = resp_mem;
        cnt_m = 0; rd_m = 0; ov_m = 0; outstanding = 0; hold = 0; ack_cnt = 0; rv_cnt = 0;
        #2;
        check("rst_wr_full", wr_full, 0);
        check("rst_rd_empty", rd_empty, 1);
        check("rst_readdata", readdata, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic wait_room();
        for (int i = 0; i < 50 && cnt_m >= CMD_DEPTH - 1; i++) tick();
        check("room", wr_full, 0);
    endtask

    initial begin
        int  w0, r0, q0;
        bit  got;
        #1;
        do_reset();

        // reset while a write sits in ISSUE without ack
        ack_hold = 1;
        writeaddr = 16'h0002; writedata = 16'h0BAD; write = 1; tick(); write = 0;
        tick();
        check("t1_issue", mem_req, 1);
        tick();
        do_reset();
        ack_hold = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_quiet", mem_req, 0);
        end

        // single write, immediate ack
        ack_dly = 0;
        writeaddr = 16'h0001; writedata = 16'h00A5; write = 1; tick(); write = 0;
        check("t2_n1", mem_req, 0);
        tick();
        check("t2_req", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'h0001, 16'h00A5});
        tick();
        check("t2_done", mem_req, 0);
        check("t2_busy", busy, 0);

        // same-cycle write and read to one address, read latency 3
        lat = 3;
        writeaddr = 16'h0003; writedata = 16'h1234; readaddr = 16'h0003;
        write = 1; read = 1; tick(); write = 0; read = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = mem_rvalid;
        end
        check("t3_rvalid", got, 1);
        tick();
        check("t3_empty", rd_empty, 0);
        check("t3_data", readdata, 16'h1234);
        rd_pop = 1; tick(); rd_pop = 0;
        check("t3_pop", rd_empty, 1);

        // five reads with no consumer: only RD_DEPTH issue
        lat = 1;
        r0 = n_rd;
        for (int i = 0; i < 5; i++) begin
            wait_room();
            readaddr = 16'h0010 + 16'(i); read = 1; tick(); read = 0;
        end
        repeat (20) tick();
        check("t4_four", n_rd - r0, 4);
        check("t4_queued", busy, 1);
        rd_pop = 1; tick(); rd_pop = 0;
        repeat (8) tick();
        check("t4_fifth", n_rd - r0, 5);
        rd_pop = 1;
        repeat (4) tick();
        rd_pop = 0;
        check("t4_drained", rd_empty, 1);

        // fill the command queue while ack is withheld
        ack_hold = 1;
        w0 = n_wr;
        for (int i = 0; i < 3; i++) begin
            writeaddr = 16'h0020 + 16'(i); writedata = 16'hC000 + 16'(i); write = 1; tick();
        end
        write = 0;
        check("t5_full", wr_full, 1);
        check("t5_no_ov", overflow, 0);
        writeaddr = 16'h002F; writedata = 16'hDEAD; write = 1; tick(); write = 0;
        check("t5_ov", overflow, 1);
        ack_hold = 0;
        repeat (12) tick();
        check("t5_three", n_wr - w0, 3);

        // ack delayed five cycles
        ack_dly = 5;
        w0 = n_wr; q0 = n_req;
        writeaddr = 16'h0040; writedata = 16'h5A5A; write = 1; tick(); write = 0;
        repeat (12) tick();
        check("t6_one", n_wr - w0, 1);
        check("t6_len", n_req - q0, 6);
        ack_dly = 0;

        // randomized traffic
        do_reset();
        rand_mode = 1;
        repeat (600) begin
            write = $urandom_range(0, 3) == 0;
            writeaddr = 16'($urandom_range(0, 7));
            writedata = 16'($urandom);
            read = $urandom_range(0, 3) == 0;
            readaddr = 16'($urandom_range(0, 7));
            rd_pop = $urandom_range(0, 2) == 0;
            tick();
        end
        write = 0; read = 0; rd_pop = 1;
        for (int i = 0; i < 200 && (cnt_m != 0 || outstanding || rd_m != 0); i++) tick();
        rd_pop = 0;
        check("drain_cmd", exp_cmd.size(), 0);
        check("drain_rd", rd_empty, 1);
        check("drain_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
